mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive grants to requester 0 while requester 1 is waiting (fixed-priority mode only); legal range 1..15.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-004 REQ  in  2  request per requester; index 0 = CPU data port, index 1 = DMA/debug port.
REQ-005 WE  in  2  per requester: 1 = store, 0 = load.
REQ-006 ADDR  in  2x32  per-requester byte address; bit 16 and above = MMIO.
REQ-007 DIN  in  2x32  per-requester store data.
REQ-008 SIZE  in  2x2  per-requester size: 0 byte, 1 half, 2 word.
REQ-009 SIGN  in  2  per requester: 1 = unsigned, 0 = signed load.
REQ-010 GNT  out  2  one-cycle pulse when a request is accepted; one-hot or zero.
REQ-011 RVALID  out  2  one-cycle pulse to the load owner when RDATA is valid.
REQ-012 RDATA  out  32  shared load data; MEM_DOUT2 while any RVALID bit is set, else 0.
REQ-013 MEM_RDEN2, MEM_WE2  out  1 each  memory data-port read and write enables.
REQ-014 MEM_ADDR2, MEM_DIN2  out  32 each  memory data-port address and store data.
REQ-015 MEM_SIZE  out  2, MEM_SIGN  out  1  memory access size and sign.
REQ-016 MEM_DOUT2  in  32  memory sized load data, valid one cycle after the MEM_RDEN2 edge.

Function
REQ-017 FSM states: IDLE, ACCESS, RDATA.
REQ-018 GNT is asserted only in IDLE: combinational from REQ and the arbitration winner.
REQ-019 The granted requester's WE, ADDR, DIN, SIZE and SIGN are captured in the grant cycle.
REQ-020 IDLE goes to ACCESS on any grant; otherwise IDLE holds.
REQ-021 ACCESS drives captured fields to the MEM_* outputs, with MEM_WE2 = captured WE and MEM_RDEN2 = not captured WE.
REQ-022 ACCESS goes to IDLE for a store and to RDATA for a load.
REQ-023 RDATA holds MEM_ADDR2, MEM_SIZE and MEM_SIGN at their captured values, with MEM_RDEN2 = MEM_WE2 = 0.
REQ-024 RDATA pulses RVALID for the owner, then goes to IDLE.
REQ-025 Latency: a store completes 1 cycle after GNT; load data (RVALID) appears 2 cycles after GNT.
REQ-026 Peak throughput: one store per 2 cycles, one load per 3 cycles.
REQ-027 Outside ACCESS and RDATA, all MEM_* outputs are 0.
REQ-028 Requesters hold REQ and fields until GNT; a REQ dropped before GNT is lost without error.
REQ-029 Fixed priority (macro absent): requester 0 wins.
REQ-030 Fixed priority burst limit: a 4-bit counter counts consecutive requester-0 grants while REQ[1] = 1; when the count equals MAX_BURST, requester 1 wins the next arbitration.
REQ-031 The burst counter clears on any requester-1 grant and on any IDLE cycle with REQ[1] = 0.
REQ-032 Simultaneous REQ with an empty history: requester 0 wins in both modes.

Reset
REQ-033 RST_N low immediately forces: state IDLE; GNT, RVALID, RDATA and all MEM_* outputs 0; captured fields 0; burst counter 0; round-robin pointer pointing to requester 0.
REQ-034 Reset mid-ACCESS or mid-RDATA abandons the transaction with no RVALID, and the first grant is possible on the first edge after release.

Configuration
REQ-035 Macro MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
REQ-036 Round-robin rule: a 1-bit pointer toggles on every grant, and the pointed requester wins when both request; MAX_BURST and the burst counter are not built.
REQ-037 Macro MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority with burst limit (REQ-029..031).

Structure
REQ-038 Shared package mem_arb_pkg holds the state enum, size encodings (BYTE=0, HALF=1, WORD=2) and MMIO_BASE = 32'h0001_0000.
REQ-039 One sub-module, mem_arb_pick: combinational winner select from REQ, pointer or burst count; no other hierarchy.

Verification
REQ-040 Store: REQ=01, WE[0]=1, ADDR=0x100, DIN=0xDEADBEEF, SIZE=2 -> GNT=01, then next cycle MEM_WE2=1, MEM_ADDR2=0x100, MEM_DIN2=0xDEADBEEF, then IDLE.
REQ-041 Load: REQ=10, ADDR=0x102, SIZE=1, SIGN=0, memory returns 0xFFFF8000 -> MEM_RDEN2 one cycle after GNT, MEM_ADDR2 held through RDATA, RVALID=10 and RDATA=0xFFFF8000 two cycles after GNT.
REQ-042 Contention, fixed priority, MAX_BURST=4: both REQ held with loads -> GNT sequence 01,01,01,01,10,01.
REQ-043 Contention with MEM_ARB_ROUND_ROBIN_EN: both REQ held -> GNT alternates 01,10,01,10; simultaneous first request grants 01.
REQ-044 Reset: RST_N low during RDATA -> all outputs 0 immediately, no RVALID; after release with REQ=01, GNT on the first edge.
REQ-045 MMIO: load at ADDR=0x11000 -> MEM_ADDR2=0x11000 with MEM_RDEN2 pulse, and RVALID delivers IO data 2 cycles after GNT.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory data-port arbiter:
//   - arb_state_t : arbiter FSM states (IDLE / ACCESS / RDATA)
//   - BYTE/HALF/WORD : access size encodings carried on SIZE / MEM_SIZE
//   - MMIO_BASE : first byte address that decodes to memory-mapped IO
//   - is_mmio() : address classifier for users of the package
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } arb_state_t;

    localparam logic [1:0]  BYTE = 2'd0;
    localparam logic [1:0]  HALF = 2'd1;
    localparam logic [1:0]  WORD = 2'd2;

    localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

    function automatic logic is_mmio(input logic [31:0] addr);
        return addr >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select for the two requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   : contention resolved by the round-robin pointer
//   undefined : requester 0 wins unless its burst count reached MAX_BURST
// Ports:
//   req        in  2  live request vector
//   ptr        in  1  round-robin pointer (round-robin build only)
//   burst_cnt  in  4  consecutive requester-0 grants (fixed build only)
//   win        out 2  one-hot winner, zero when nobody requests
// ---------------------------------------------------------------------------
module mem_arb_pick #(
    parameter int MAX_BURST = 4
) (
    input  logic [1:0] req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic       ptr,
`else
    input  logic [3:0] burst_cnt,
`endif
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            2'b11:   win = ptr ? 2'b10 : 2'b01;
`else
            // requester 1 only overtakes once requester 0 used its burst
            2'b11:   win = (burst_cnt == 4'(MAX_BURST)) ? 2'b10 : 2'b01;
`endif
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory data port between the CPU data port (requester 0) and
// the DMA/debug port (requester 1). A grant captures the winner's request,
// drives it onto the MEM_* port for one cycle (ACCESS) and, for loads,
// returns MEM_DOUT2 to the owner one cycle later (RDATA).
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// otherwise fixed priority to requester 0 with a MAX_BURST limit.
// Ports:
//   CLK, RST_N              clock, async active-low reset
//   REQ/WE/SIGN [1:0]       per-requester request, store flag, unsigned flag
//   ADDR/DIN [63:0]         per-requester address / store data, req i at [32i+:32]
//   SIZE [3:0]              per-requester size, req i at [2i+:2]
//   GNT, RVALID [1:0]       grant pulse, load-data-valid pulse (one-hot)
//   RDATA [31:0]            load data, zero unless RVALID is set
//   MEM_RDEN2, MEM_WE2      memory read / write enables
//   MEM_ADDR2, MEM_DIN2     memory address / store data
//   MEM_SIZE, MEM_SIGN      memory access size / sign
//   MEM_DOUT2 [31:0]        memory load data, valid the cycle after MEM_RDEN2
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  REQ,
    input  logic [1:0]  WE,
    input  logic [63:0] ADDR,
    input  logic [63:0] DIN,
    input  logic [3:0]  SIZE,
    input  logic [1:0]  SIGN,
    output logic [1:0]  GNT,
    output logic [1:0]  RVALID,
    output logic [31:0] RDATA,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    arb_state_t  state, state_nxt;
    logic [1:0]  win;

    logic        cap_owner;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_din;
    logic [1:0]  cap_size;
    logic        cap_sign;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        rr_ptr;

    mem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .req (REQ),
        .ptr (rr_ptr),
        .win (win)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            rr_ptr <= 1'b0;
        else if (GNT != 2'b00)
            rr_ptr <= ~rr_ptr;
    end
`else
    logic [3:0]  burst_cnt;

    mem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .req       (REQ),
        .burst_cnt (burst_cnt),
        .win       (win)
    );

    // Counts requester-0 grants only while requester 1 is kept waiting;
    // it cannot pass MAX_BURST because reaching it hands the next
    // contended arbitration to requester 1, which clears it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            burst_cnt <= 4'd0;
        else if (state == ST_IDLE) begin
            if (!REQ[1] || GNT[1])
                burst_cnt <= 4'd0;
            else if (GNT[0])
                burst_cnt <= burst_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // GNT is qualified with RST_N so a held request cannot show a grant
    // while reset is asserted.
    always_comb begin
        state_nxt = state;
        GNT       = 2'b00;
        RVALID    = 2'b00;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        MEM_ADDR2 = 32'd0;
        MEM_DIN2  = 32'd0;
        MEM_SIZE  = 2'd0;
        MEM_SIGN  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RST_N && win != 2'b00) begin
                    GNT       = win;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                MEM_WE2   = cap_we;
                MEM_RDEN2 = ~cap_we;
                MEM_ADDR2 = cap_addr;
                MEM_DIN2  = cap_din;
                MEM_SIZE  = cap_size;
                MEM_SIGN  = cap_sign;
                state_nxt = cap_we ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
                // address/size/sign stay up while the memory returns data
                MEM_ADDR2 = cap_addr;
                MEM_SIZE  = cap_size;
                MEM_SIGN  = cap_sign;
                RVALID    = cap_owner ? 2'b10 : 2'b01;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign RDATA = (RVALID != 2'b00) ? MEM_DOUT2 : 32'd0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cap_owner <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_din   <= 32'd0;
            cap_size  <= 2'd0;
            cap_sign  <= 1'b0;
        end else if (GNT != 2'b00) begin
            cap_owner <= win[1];
            cap_we    <= win[1] ? WE[1]        : WE[0];
            cap_addr  <= win[1] ? ADDR[63:32]  : ADDR[31:0];
            cap_din   <= win[1] ? DIN[63:32]   : DIN[31:0];
            cap_size  <= win[1] ? SIZE[3:2]    : SIZE[1:0];
            cap_sign  <= win[1] ? SIGN[1]      : SIGN[0];
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios (reset, store, load, MMIO load, contention, reset
// during load return) plus randomized two-requester traffic compared each
// cycle against a transaction-level schedule model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int MAX_BURST = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [1:0]  REQ, WE, SIGN;
    logic [63:0] ADDR, DIN;
    logic [3:0]  SIZE;
    logic [1:0]  GNT, RVALID;
    logic [31:0] RDATA;
    logic        MEM_RDEN2, MEM_WE2;
    logic [31:0] MEM_ADDR2, MEM_DIN2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .WE        (WE),
        .ADDR      (ADDR),
        .DIN       (DIN),
        .SIZE      (SIZE),
        .SIGN      (SIGN),
        .GNT       (GNT),
        .RVALID    (RVALID),
        .RDATA     (RDATA),
        .MEM_RDEN2 (MEM_RDEN2),
        .MEM_WE2   (MEM_WE2),
        .MEM_ADDR2 (MEM_ADDR2),
        .MEM_DIN2  (MEM_DIN2),
        .MEM_SIZE  (MEM_SIZE),
        .MEM_SIGN  (MEM_SIGN),
        .MEM_DOUT2 (MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    // memory contents as a pure function of address; MMIO space returns
    // a tagged IO pattern
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0102) return 32'hFFFF_8000;
        if (a >= 32'h0001_0000) return 32'h1000_0000 | a;
        return a * 32'h9E37_79B1;
    endfunction

    // memory data port: sized data one cycle after a read edge, junk otherwise
    always @(posedge CLK) begin
        if (MEM_RDEN2) MEM_DOUT2 <= mem_fn(MEM_ADDR2);
        else           MEM_DOUT2 <= $urandom;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        REQ = '0; WE = '0; SIGN = '0; ADDR = '0; DIN = '0; SIZE = '0;
    endtask

    task automatic set_req(input int r, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz, input logic sg);
        REQ[r]          = 1'b1;
        WE[r]           = we;
        ADDR[32*r +: 32] = a;
        DIN[32*r +: 32]  = d;
        SIZE[2*r +: 2]  = sz;
        SIGN[r]         = sg;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic test_reset();
        logic [104:0] act;
        clear_inputs();
        RST_N = 1'b0;
        REQ   = 2'b11;
        #3;
        act = {GNT, RVALID, RDATA, MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN};
        tests++;
        if (act !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", act);
        end
        @(posedge CLK); #1;
        act = {GNT, RVALID, RDATA, MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN};
        tests++;
        if (act !== '0) begin
            fails++;
            $display("FAIL reset_held_after_edge: got %h want 0", act);
        end
        clear_inputs();
    endtask

    task automatic test_store();
        do_reset();
        set_req(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0);
        @(negedge CLK);
        tests++;
        if (GNT !== 2'b01) begin
            fails++;
            $display("FAIL store_gnt: got %b want 01", GNT);
        end
        next_cycle();
        REQ = 2'b00;
        @(negedge CLK);
        tests++;
        if ({GNT, MEM_WE2, MEM_RDEN2, MEM_ADDR2, MEM_DIN2, MEM_SIZE} !==
            {2'b00, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 2'd2}) begin
            fails++;
            $display("FAIL store_access: got gnt=%b we=%b rd=%b a=%h d=%h sz=%0d want gnt=00 we=1 rd=0 a=100 d=deadbeef sz=2",
                     GNT, MEM_WE2, MEM_RDEN2, MEM_ADDR2, MEM_DIN2, MEM_SIZE);
        end
        next_cycle();
        @(negedge CLK);
        tests++;
        if ({RVALID, MEM_WE2, MEM_RDEN2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN} !== '0) begin
            fails++;
            $display("FAIL store_idle_after: got rv=%b we=%b rd=%b a=%h want all 0",
                     RVALID, MEM_WE2, MEM_RDEN2, MEM_ADDR2);
        end
    endtask

    // load with the given requester; checks grant, access, data return
    task automatic run_load(input string nm, input int r, input logic [31:0] a,
                            input logic [1:0] sz, input logic sg);
        logic [1:0] own;
        own = (r == 1) ? 2'b10 : 2'b01;
        do_reset();
        set_req(r, 1'b0, a, 32'h5555_AAAA, sz, sg);
        @(negedge CLK);
        tests++;
        if (GNT !== own) begin
            fails++;
            $display("FAIL %s_gnt: got %b want %b", nm, GNT, own);
        end
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        tests++;
        if ({MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_SIZE, MEM_SIGN, RVALID} !==
            {1'b1, 1'b0, a, sz, sg, 2'b00}) begin
            fails++;
            $display("FAIL %s_access: got rd=%b we=%b a=%h sz=%0d sg=%b rv=%b want rd=1 we=0 a=%h sz=%0d sg=%b rv=00",
                     nm, MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_SIZE, MEM_SIGN, RVALID, a, sz, sg);
        end
        next_cycle();
        @(negedge CLK);
        tests++;
        if ({RVALID, RDATA, MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_SIZE, MEM_SIGN} !==
            {own, mem_fn(a), 1'b0, 1'b0, a, sz, sg}) begin
            fails++;
            $display("FAIL %s_rdata: got rv=%b d=%h rd=%b a=%h want rv=%b d=%h rd=0 a=%h",
                     nm, RVALID, RDATA, MEM_RDEN2, MEM_ADDR2, own, mem_fn(a), a);
        end
        next_cycle();
        @(negedge CLK);
        tests++;
        if ({RVALID, RDATA, MEM_ADDR2} !== '0) begin
            fails++;
            $display("FAIL %s_done: got rv=%b d=%h a=%h want 0", nm, RVALID, RDATA, MEM_ADDR2);
        end
    endtask

    task automatic test_load();
        run_load("load", 1, 32'h102, 2'd1, 1'b0);
    endtask

    task automatic test_mmio();
        run_load("mmio", 0, 32'h0001_1000, 2'd2, 1'b1);
    endtask

    task automatic test_contention();
        logic [1:0] seen[$];
        logic [1:0] want[6];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        want = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        want = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`endif
        do_reset();
        set_req(0, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        set_req(1, 1'b0, 32'h80, 32'h0, 2'd2, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (GNT !== 2'b00) seen.push_back(GNT);
            next_cycle();
        end
        tests++;
        if (seen.size() < 6) begin
            fails++;
            $display("FAIL contention_count: got %0d grants want >=6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (seen[i] !== want[i]) begin
                    fails++;
                    $display("FAIL contention_gnt%0d: got %b want %b", i, seen[i], want[i]);
                end
            end
        end
        clear_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_mid_rdata();
        logic [104:0] act;
        do_reset();
        set_req(0, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
        @(negedge CLK);
        next_cycle();
        clear_inputs();
        next_cycle();                       // now in the load-return cycle
        RST_N = 1'b0;
        set_req(0, 1'b1, 32'h300, 32'h1234_5678, 2'd2, 1'b0);
        #1;
        act = {GNT, RVALID, RDATA, MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN};
        tests++;
        if (act !== '0) begin
            fails++;
            $display("FAIL rst_mid_rdata_outputs: got %h want 0", act);
        end
        @(negedge CLK);
        tests++;
        if ({GNT, RVALID} !== 4'b0) begin
            fails++;
            $display("FAIL rst_mid_rdata_hold: got gnt=%b rv=%b want 00 00", GNT, RVALID);
        end
        @(posedge CLK);
        #1 RST_N = 1'b1;
        #1;
        tests++;
        if (GNT !== 2'b01) begin
            fails++;
            $display("FAIL rst_release_gnt: got %b want 01", GNT);
        end
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        tests++;
        if ({MEM_WE2, MEM_ADDR2, MEM_DIN2, RVALID} !== {1'b1, 32'h300, 32'h1234_5678, 2'b00}) begin
            fails++;
            $display("FAIL rst_release_store: got we=%b a=%h d=%h rv=%b want we=1 a=300 d=12345678 rv=00",
                     MEM_WE2, MEM_ADDR2, MEM_DIN2, RVALID);
        end
        next_cycle();
    endtask

    // Reference: each granted transaction occupies the port for its access
    // cycle (plus a data-return cycle for loads); arbitration happens only
    // on cycles where the port is free.
    task automatic test_random_traffic();
        int          t, free_t, acc_t, cnt;
        logic        ptr, acc_valid, acc_we, acc_sign, acc_owner;
        logic [31:0] acc_addr, acc_din;
        logic [1:0]  acc_size, prev_gnt, exp_gnt, exp_rv;
        logic [31:0] exp_rdata, exp_addr, exp_din, a;
        logic        exp_rden, exp_we, exp_sign, granted, w;
        logic [1:0]  exp_size;
        logic [104:0] exp_vec, act_vec;
        int          bad;

        do_reset();
        t = 0; free_t = 0; acc_t = -10; cnt = 0; ptr = 1'b0; acc_valid = 1'b0;
        acc_we = 1'b0; acc_sign = 1'b0; acc_owner = 1'b0; acc_addr = '0; acc_din = '0;
        acc_size = '0; prev_gnt = '0; bad = 0;

        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (prev_gnt[r]) REQ[r] = 1'b0;
                if (REQ[r] && $urandom_range(0, 15) == 0)
                    REQ[r] = 1'b0;          // requester gives up before grant
                else if (!REQ[r] && $urandom_range(0, 9) < 6) begin
                    a = $urandom_range(0, 1) ? ($urandom & 32'hFFFF)
                                             : (32'h0001_0000 + ($urandom & 32'hFFFF));
                    set_req(r, 1'($urandom_range(0, 1)), a, $urandom,
                            2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                end
            end
            @(negedge CLK);

            exp_gnt = '0; exp_rv = '0; exp_rdata = '0; exp_rden = 1'b0; exp_we = 1'b0;
            exp_addr = '0; exp_din = '0; exp_size = '0; exp_sign = 1'b0;
            if (acc_valid && t == acc_t) begin
                exp_we = acc_we; exp_rden = ~acc_we; exp_addr = acc_addr;
                exp_din = acc_din; exp_size = acc_size; exp_sign = acc_sign;
            end else if (acc_valid && !acc_we && t == acc_t + 1) begin
                exp_addr = acc_addr; exp_size = acc_size; exp_sign = acc_sign;
                exp_rv = acc_owner ? 2'b10 : 2'b01;
                exp_rdata = mem_fn(acc_addr);
            end

            if (t >= free_t) begin
                granted = (REQ != 2'b00);
                if (REQ == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    w = ptr;
`else
                    w = (cnt == MAX_BURST);
`endif
                end else
                    w = REQ[1];
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (granted) ptr = ~ptr;
`else
                if (!REQ[1] || (granted && w)) cnt = 0;
                else if (granted) cnt = cnt + 1;
`endif
                if (granted) begin
                    exp_gnt   = w ? 2'b10 : 2'b01;
                    acc_valid = 1'b1;
                    acc_owner = w;
                    acc_we    = WE[w];
                    acc_addr  = w ? ADDR[63:32] : ADDR[31:0];
                    acc_din   = w ? DIN[63:32]  : DIN[31:0];
                    acc_size  = w ? SIZE[3:2]   : SIZE[1:0];
                    acc_sign  = SIGN[w];
                    acc_t     = t + 1;
                    free_t    = acc_we ? t + 2 : t + 3;
                end
            end

            exp_vec = {exp_gnt, exp_rv, exp_rdata, exp_rden, exp_we, exp_addr, exp_din, exp_size, exp_sign};
            act_vec = {GNT, RVALID, RDATA, MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN};
            tests++;
            if (act_vec !== exp_vec) begin
                fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle%0d: got %h want %h (gnt,rv,rdata,rd,we,addr,din,size,sign)",
                             t, act_vec, exp_vec);
            end
            prev_gnt = exp_gnt;
            t++;
            next_cycle();
        end
        clear_inputs();
        repeat (3) next_cycle();
    endtask

    initial begin
        clear_inputs();
        RST_N = 1'b0;
        test_reset();
        test_store();
        test_load();
        test_mmio();
        test_contention();
        test_reset_mid_rdata();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
